// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: finds the start bit, times mid-bit sampling and strobes an external
// shift register once per data bit, then checks the stop bit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge while enable is high
// START     | timing to the start-bit centre to confirm it is still low
// DATA      | one shift_en strobe per bit period at each data-bit centre
// STOP      | sampling the stop bit at its centre
// WAIT_HIGH | stop bit was low; holding until the line returns high
module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       rx_serial,
  input  logic       enable,
  output logic       shift_en,
  output logic       sample_bit,
  output logic [3:0] bit_index,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_IDX = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic             fall;

  // Synchronizer resets to the idle-high level so leaving reset never looks like a start bit.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_index  <= 4'd0;
      shift_en   <= 1'b0;
      sample_bit <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      shift_en   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (fall && enable) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == HALF_TC) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= S_DATA;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == FULL_TC) begin
            cnt        <= '0;
            shift_en   <= 1'b1;
            sample_bit <= rx_s;
            if (bit_index == LAST_IDX) begin
              bit_index <= 4'd0;
              state     <= S_STOP;
            end else begin
              bit_index <= bit_index + 4'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == FULL_TC) begin
            cnt <= '0;
            if (rx_s) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          bit_index <= 4'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
